// File: rtl/dmem_block_mover.sv
// dmem_block_mover: autonomous data-memory initiator for block FILL, COPY and
// VERIFY-against-constant. It is muxed onto the data-memory port while busy.
//
// Memory handshake: a request line (memread or memwrite) is high for one REQ
// cycle and then for every WAIT cycle. Address, write data and sign mask are
// stable for that whole window. An access completes on the first rising edge
// in WAIT with mem_clk_stall low, and read data is sampled on that edge. The
// request line is low for exactly one cycle after completion before the next
// REQ. That cycle is the "gap": the FSM stays in WAIT with r_gap set.
module dmem_block_mover #(
  parameter int         LEN_W          = 16,
  parameter logic [3:0] SIGN_MASK_WORD = 4'b1111,
  parameter int         STALL_TIMEOUT  = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len_words,
  input  logic [31:0]      i_pattern,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [31:0]      o_fail_addr,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_write_data,
  output logic             o_mem_memwrite,
  output logic             o_mem_memread,
  output logic [3:0]       o_mem_sign_mask,
  input  logic [31:0]      i_mem_read_data,
  input  logic             i_mem_clk_stall,
  output logic [2:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [1:0] OP_FILL   = 2'b00;
  localparam logic [1:0] OP_COPY   = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_pattern;
  logic [31:0]      r_data;
  logic [31:0]      r_fail_addr;
  logic [LEN_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_gap;
  logic             r_error;

  logic        w_in_wait;
  logic        w_complete;
  logic        w_timeout;
  logic        w_mismatch;
  logic        w_last;
  logic        w_accept;
  logic        w_req_rd;
  logic        w_req_wr;
  logic [31:0] w_rd_addr;
  logic [31:0] w_cur_addr;

  assign w_in_wait  = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_complete = w_in_wait && !r_gap && !i_mem_clk_stall;
  assign w_timeout  = w_in_wait && !r_gap && i_mem_clk_stall &&
                      (r_wait_cnt == CNT_W'(STALL_TIMEOUT - 1));
  assign w_mismatch = (r_state == S_RD_WAIT) && (r_op == OP_VERIFY) && w_complete &&
                      (i_mem_read_data != r_pattern);
  assign w_last     = (r_remaining == LEN_W'(1));
  assign w_accept   = (r_state == S_IDLE) && i_start;
  // COPY reads from the source pointer; VERIFY reads the destination region.
  assign w_rd_addr  = (r_op == OP_COPY) ? r_src : r_dst;
  assign w_cur_addr = ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) ? w_rd_addr : r_dst;

  // State register; reset abandons any transfer and drops requests at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic and all combinational outputs.
  always_comb begin
    w_next           = r_state;
    w_req_rd         = 1'b0;
    w_req_wr         = 1'b0;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    o_mem_addr       = '0;
    o_mem_write_data = '0;
    o_mem_sign_mask  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_op == OP_RSVD)            w_next = S_IDLE;
          else if (i_len_words == '0)     w_next = S_FINISH;
          else if (i_op == OP_FILL)       w_next = S_WR_REQ;
          else                            w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: w_next = S_RD_WAIT;
      S_WR_REQ: w_next = S_WR_WAIT;
      S_RD_WAIT: begin
        if (r_gap)                                       w_next = (r_op == OP_COPY) ? S_WR_REQ : S_RD_REQ;
        else if (w_timeout || w_mismatch)                w_next = S_IDLE;
        else if (w_complete && (r_op != OP_COPY) && w_last) w_next = S_FINISH;
      end
      S_WR_WAIT: begin
        if (r_gap)                     w_next = (r_op == OP_COPY) ? S_RD_REQ : S_WR_REQ;
        else if (w_timeout)            w_next = S_IDLE;
        else if (w_complete && w_last) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    w_req_rd = (r_state == S_RD_REQ) || ((r_state == S_RD_WAIT) && !r_gap);
    w_req_wr = (r_state == S_WR_REQ) || ((r_state == S_WR_WAIT) && !r_gap);
    o_busy   = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
               (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
    o_done   = (r_state == S_FINISH);
    if (w_req_rd || w_req_wr) begin
      o_mem_addr      = w_cur_addr;
      o_mem_sign_mask = SIGN_MASK_WORD;
    end
    if (w_req_wr) o_mem_write_data = (r_op == OP_COPY) ? r_data : r_pattern;
  end

  // Command latch, pointers, word counter, wait counter and error reporting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op        <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_pattern   <= '0;
      r_data      <= '0;
      r_fail_addr <= '0;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_gap       <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      // A completion that keeps the FSM in WAIT means another access follows.
      r_gap   <= w_complete && (w_next == r_state);
      if (w_accept) begin
        r_op        <= i_op;
        r_src       <= i_src_addr & ~32'd3;
        r_dst       <= i_dst_addr & ~32'd3;
        r_pattern   <= i_pattern;
        r_remaining <= i_len_words;
        r_fail_addr <= '0;
        if (i_op == OP_RSVD) r_error <= 1'b1;
      end
      if ((r_state == S_RD_REQ) || (r_state == S_WR_REQ))
        r_wait_cnt <= '0;
      else if (w_in_wait && !r_gap && i_mem_clk_stall)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout) begin
        r_fail_addr <= w_cur_addr;
        r_error     <= 1'b1;
      end
      if (w_mismatch) begin
        r_fail_addr <= r_dst;
        r_error     <= 1'b1;
      end
      if (w_complete && !w_mismatch) begin
        if ((r_state == S_RD_WAIT) && (r_op == OP_COPY)) begin
          r_data <= i_mem_read_data;
          r_src  <= r_src + 32'd4;
        end else begin
          // Last access of an element: advance destination and count it.
          r_dst       <= r_dst + 32'd4;
          r_remaining <= r_remaining - LEN_W'(1);
        end
      end
    end
  end

  assign o_mem_memread  = w_req_rd;
  assign o_mem_memwrite = w_req_wr;
  assign o_error        = r_error;
  assign o_fail_addr    = r_fail_addr;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Testbench for dmem_block_mover: memory responder with programmable stalls,
// command-level reference model feeding expected queues, decoupled monitor.
module tb_dmem_block_mover;

  localparam int LEN_W    = 16;
  localparam int STALL_TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic [31:0]      pattern;
  logic             busy;
  logic             done;
  logic             error;
  logic [31:0]      fail_addr;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_write_data;
  logic             mem_memwrite;
  logic             mem_memread;
  logic [3:0]       mem_sign_mask;
  logic [31:0]      mem_read_data = '0;
  logic             mem_clk_stall = 1'b0;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected accesses {is_write, addr, data} and command endings {is_error, fail_addr}.
  logic [64:0] exp_q[$];
  logic [32:0] exp_end_q[$];

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          stall_forever = 1'b0;
  bit          stall_rand    = 1'b0;
  int          stall_fixed   = 0;
  int          age           = 0;
  int          cur_stall     = 0;
  bit          comp          = 1'b0;
  bit          pend_wr       = 1'b0;
  logic [31:0] pend_addr, pend_data, hold_addr, hold_wd;
  int          req_cnt       = 0;
  int          wr_hi_cnt     = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dmem_block_mover #(.LEN_W(LEN_W), .SIGN_MASK_WORD(4'b1111), .STALL_TIMEOUT(STALL_TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len_words(len_words),
    .i_pattern(pattern), .o_busy(busy), .o_done(done), .o_error(error),
    .o_fail_addr(fail_addr), .o_mem_addr(mem_addr), .o_mem_write_data(mem_write_data),
    .o_mem_memwrite(mem_memwrite), .o_mem_memread(mem_memread),
    .o_mem_sign_mask(mem_sign_mask), .i_mem_read_data(mem_read_data),
    .i_mem_clk_stall(mem_clk_stall), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [64:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h expected nothing at %0t", name, act, $time);
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Reference model: the word-level effect of one command.
  task automatic model_cmd(input logic [1:0] o, input logic [31:0] s, input logic [31:0] d,
                           input int l, input logic [31:0] p);
    logic [31:0] sa, da, v;
    sa = s & ~32'd3;
    da = d & ~32'd3;
    if (o == 2'b11) begin exp_end_q.push_back({1'b1, 32'd0}); return; end
    if (l == 0)     begin exp_end_q.push_back({1'b0, 32'd0}); return; end
    if (stall_forever) begin
      exp_end_q.push_back({1'b1, (o == 2'b01) ? sa : da});
      return;
    end
    for (int i = 0; i < l; i++) begin
      case (o)
        2'b00: begin
          exp_q.push_back({1'b1, da, p});
          ref_mem[da] = p;
        end
        2'b01: begin
          v = ref_get(sa);
          exp_q.push_back({1'b0, sa, v});
          exp_q.push_back({1'b1, da, v});
          ref_mem[da] = v;
        end
        default: begin
          v = ref_get(da);
          exp_q.push_back({1'b0, da, v});
          if (v != p) begin exp_end_q.push_back({1'b1, da}); return; end
        end
      endcase
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
    exp_end_q.push_back({1'b0, 32'd0});
  endtask

  // Responder: samples the request just after each edge, drives stall and
  // read data, and commits a write once the completing edge has passed.
  always @(posedge clk) begin
    #1;
    if (pend_wr) begin
      mem[pend_addr] = pend_data;
      pend_wr = 1'b0;
    end
    comp = 1'b0;
    if (!rst && (mem_memread || mem_memwrite)) begin
      age++;
      if (age == 1) begin
        req_cnt++;
        cur_stall = stall_rand ? int'($urandom_range(0, 3)) : stall_fixed;
        hold_addr = mem_addr;
        hold_wd   = mem_write_data;
      end
      mem_clk_stall = stall_forever || (age <= 1 + cur_stall);
      mem_read_data = mem_memread ? mem_get(mem_addr) : $urandom;
      comp = !mem_clk_stall && (age >= 2);
      if (comp && mem_memwrite) begin
        pend_wr   = 1'b1;
        pend_addr = mem_addr;
        pend_data = mem_write_data;
      end
    end else begin
      age           = 0;
      mem_clk_stall = 1'($urandom_range(0, 1));
      mem_read_data = $urandom;
    end
  end

  // Monitor: pops expectations whenever the DUT completes an access or ends.
  always @(negedge clk) begin
    logic [64:0] e;
    logic [32:0] ee;
    if (!rst) begin
      if (mem_memwrite) wr_hi_cnt++;
      if (mem_memread && mem_memwrite) fail_now("read_and_write", 1);
      if (mem_memread || mem_memwrite) begin
        check("sign_mask", mem_sign_mask, 4'hF);
        if (age >= 2) begin
          check("hold_addr", mem_addr, hold_addr);
          check("hold_wdata", mem_write_data, hold_wd);
        end
      end
      if (comp) begin
        if (exp_q.size() == 0) fail_now("unexpected_access", {mem_memwrite, mem_addr});
        else begin
          e = exp_q.pop_front();
          check("access", {mem_memwrite, mem_addr, mem_memwrite ? mem_write_data : mem_read_data}, e);
        end
      end
      if (done && error) fail_now("done_and_error", 1);
      if (done || error) begin
        if (exp_end_q.size() == 0) fail_now("unexpected_end", {error, fail_addr});
        else begin
          ee = exp_end_q.pop_front();
          check("end", {error, fail_addr}, ee);
          check("busy_at_end", busy, 0);
        end
      end
    end
  end

  // Driver: issue one command, optionally poke start while busy, await its end.
  task automatic run_cmd(input logic [1:0] o, input logic [31:0] s, input logic [31:0] d,
                         input int l, input logic [31:0] p, input bit poke);
    bit expect_busy;
    int k;
    expect_busy = (o != 2'b11) && (l != 0);
    model_cmd(o, s, d, l, p);
    @(negedge clk);
    start = 1'b1; op = o; src_addr = s; dst_addr = d; len_words = l[LEN_W-1:0]; pattern = p;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_addr = $urandom; dst_addr = $urandom;
    len_words = LEN_W'($urandom); pattern = $urandom;
    #1;
    if (expect_busy) check("busy_after_start", busy, 1);
    else             check("end_next_cycle", exp_end_q.size(), 0);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1; op = 2'b00; dst_addr = 32'h900; len_words = 1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (exp_end_q.size() != 0 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_end_q.size() != 0) begin
      fail_now("end_timeout", exp_end_q.size());
      exp_end_q.delete();
    end
    check("no_pending_access", exp_q.size(), 0);
    exp_q.delete();
    check("idle_after_end", {busy, mem_memread, mem_memwrite}, 0);
  endtask

  initial begin
    int          r0, ok;
    logic [1:0]  o;
    int          l, sel;
    logic [31:0] s, d, p;

    rst = 1'b1; start = 1'b0; op = '0; src_addr = '0; dst_addr = '0; len_words = '0; pattern = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, error, mem_memread, mem_memwrite, mem_sign_mask, dbg_state}, 0);
    check("reset_fail_addr", fail_addr, 0);
    check("reset_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done, error, mem_memread, mem_memwrite}, 0);

    // FILL with a fixed 2-cycle stall on every access.
    stall_fixed = 2;
    run_cmd(2'b00, 32'h100, 32'h100, 4, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++) check("fill_mem", mem_get(32'h100 + 4 * i), 32'hDEADBEEF);

    // COPY with back-to-back read/write alternation.
    stall_fixed = 0;
    preload(32'h200, 1); preload(32'h204, 2); preload(32'h208, 3);
    run_cmd(2'b01, 32'h200, 32'h300, 3, 0, 0);
    for (int i = 0; i < 3; i++) check("copy_mem", mem_get(32'h300 + 4 * i), i + 1);

    // VERIFY stops at the first bad word.
    stall_fixed = 1;
    for (int i = 0; i < 4; i++) preload(32'h400 + 4 * i, (i == 2) ? 32'h0 : 32'hA5A5A5A5);
    run_cmd(2'b10, 32'h0, 32'h400, 4, 32'hA5A5A5A5, 0);
    check("verify_fail_addr_holds", fail_addr, 32'h408);

    // Responder never releases: timeout after STALL_TO wait cycles.
    stall_forever = 1'b1;
    wr_hi_cnt = 0;
    run_cmd(2'b00, 32'h0, 32'h10, 2, 32'h12345678, 0);
    check("timeout_req_cycles", wr_hi_cnt, 1 + STALL_TO);
    check("timeout_no_write", mem.exists(32'h10), 0);
    stall_forever = 1'b0;

    // Zero-length command and reserved op make no request.
    r0 = req_cnt;
    run_cmd(2'b00, 32'h0, 32'h800, 0, 32'h1, 0);
    run_cmd(2'b11, 32'h0, 32'h800, 3, 32'h1, 0);
    check("no_request", req_cnt, r0);

    // Address wrap, then start pulsed while busy.
    run_cmd(2'b00, 32'h0, 32'hFFFFFFFE, 2, 32'hCAFEF00D, 0);
    stall_fixed = 2;
    run_cmd(2'b00, 32'h0, 32'hA00, 4, 32'h55AA55AA, 1);
    repeat (4) @(negedge clk);
    check("busy_start_ignored", mem.exists(32'h900), 0);

    // Asynchronous reset in the middle of a COPY read wait.
    // The model marks 0x700.. as written; nothing later reads that region.
    stall_fixed = 5;
    preload(32'h600, 32'h11); preload(32'h604, 32'h22);
    model_cmd(2'b01, 32'h600, 32'h700, 2, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_addr = 32'h600; dst_addr = 32'h700; len_words = 2;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = (mem_memread && age >= 3) ? 1 : 0;
    end
    check("reached_rd_wait", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("reset_drops_read", {mem_memread, mem_memwrite, busy, done, error}, 0);
    exp_q.delete();
    exp_end_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_cmd(2'b01, 32'h600, 32'h680, 2, 0, 0);
    check("copy_after_reset", mem_get(32'h684), 32'h22);

    // Randomised commands over a preloaded region.
    for (int a = 0; a < 96; a++) preload(32'h1000 + 4 * a, $urandom);
    stall_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      o   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      l   = $urandom_range(0, 6);
      s   = 32'h1000 + 4 * $urandom_range(0, 32) + $urandom_range(0, 3);
      d   = 32'h1000 + 4 * $urandom_range(0, 32) + $urandom_range(0, 3);
      p   = $urandom;
      if (o == 2'b10) begin
        if ($urandom_range(0, 1) == 1) run_cmd(2'b00, s, d, l, p, 0);
        else p = ref_get(d & ~32'd3);
      end
      run_cmd(o, s, d, l, p, 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
- Hardware initiator on the data-memory port (addr / write_data / memwrite / memread / read_data / sign_mask / clk_stall), i.e. the requesting side that the CPU normally plays.
- Performs word-granular block FILL and COPY, and VERIFY against a constant, without CPU involvement.
- Used for boot-time clearing/initialisation of data memory and for memory self-test.
- Sits beside the processor and is muxed onto the data-memory port by the top level while busy=1.

Parameters:
- LEN_W, 16, width of the word-count input (max block = 2^LEN_W-1 words).
- SIGN_MASK_WORD, 4'b1111, sign_mask value driven for a 32-bit word access.
- STALL_TIMEOUT, 64, max cycles spent in WAIT before aborting (must be ≥2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- op  in  2  00=FILL, 01=COPY, 10=VERIFY, 11=reserved (rejected with error).
- src_addr  in  32  COPY source byte address; bits[1:0] ignored (word-aligned).
- dst_addr  in  32  FILL/COPY/VERIFY target byte address; bits[1:0] ignored.
- len_words  in  LEN_W  number of words to process.
- pattern  in  32  FILL write value / VERIFY expected value.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse: command finished without error.
- error  out  1  one-cycle pulse: timeout, VERIFY mismatch, or reserved op.
- fail_addr  out  32  word address of the first mismatch or timed-out access; holds until the next start.
- mem_addr  out  32  data-memory address.
- mem_write_data  out  32  data-memory write data.
- mem_memwrite  out  1  write request.
- mem_memread  out  1  read request.
- mem_sign_mask  out  4  SIGN_MASK_WORD during any request, else 0.
- mem_read_data  in  32  data-memory read data.
- mem_clk_stall  in  1  responder busy.

Behaviour:
- Reset (asynchronous): state=IDLE, and all outputs 0, including fail_addr. Asserting reset mid-transfer drops memread/memwrite immediately; the partial transfer is abandoned with no done/error.
- Command latch at start in IDLE: op, addresses with bits[1:0] forced to 0, len_words and pattern are captured. Later input changes are ignored. start while busy is ignored.
- Command checks at start:
  - len_words=0: no memory access; done pulses the next cycle; busy stays 0.
  - op=11: no access; error pulses the next cycle; busy stays 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
  - FILL / VERIFY element flow:
    - FILL: WR_REQ, WR_WAIT, then next element.
    - VERIFY: RD_REQ, RD_WAIT, compare, then next element.
  - COPY element flow: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT. In RD_WAIT, mem_read_data is captured into a data register on completion.
- Access handshake:
  - *_REQ lasts exactly one cycle with the request line high; the request line stays high through *_WAIT.
  - mem_addr, mem_write_data and mem_sign_mask are stable from REQ until completion.
  - An access completes on the first rising edge in *_WAIT with mem_clk_stall=0. Minimum access latency is 2 cycles.
  - Read data is sampled on that same edge.
  - Request lines drop in the cycle after completion. Back-to-back accesses therefore have at least 1 idle cycle between them: the return to REQ has the request low for that single cycle.
- Timeout: a wait counter resets on entry to *_WAIT. If STALL_TIMEOUT cycles elapse with mem_clk_stall=1:
  - abort;
  - fail_addr is set to the current mem_addr;
  - error pulses;
  - the FSM returns to IDLE with requests low.
- VERIFY mismatch: on the first word where read data ≠ pattern:
  - fail_addr is set to that word's address;
  - error pulses;
  - the FSM stops at once (no further reads).
- Addressing:
  - Addresses advance by 4 per element, modulo 2^32. Wrap from 0xFFFFFFFC to 0x00000000 is legal and not an error.
  - COPY is strictly ascending. Overlapping regions with dst>src propagate data forward; this is defined behaviour, not an error.
- Counting: the remaining-word counter is LEN_W bits and decrements after each element's final access. Reaching 0 moves the FSM to FINISH.
- FINISH: done pulses for one cycle; busy falls in the same cycle; the FSM goes to IDLE. A new start is accepted in the cycle after done.
- done and error are never asserted together.

Test Plan:
- FILL: dst=0x100, len=4, pattern=0xDEADBEEF, responder stalls 2 cycles per access → writes to 0x100, 0x104, 0x108, 0x10C in order; each write request is held until stall=0; done pulses once; busy is 0 after done.
- COPY: src=0x200 preloaded with 1, 2, 3; dst=0x300; len=3 → 0x300..0x308 = 1, 2, 3; strict read/write alternation; done pulses once.
- VERIFY mismatch: region 0x400..0x40C = 0xA5A5A5A5 except 0x408 = 0; len=4 → reads stop after 0x408; error pulses; fail_addr = 0x408; no done.
- Timeout: STALL_TIMEOUT=8, responder holds stall=1 forever, FILL len=2 at dst=0x10 → error after 8 WAIT cycles; fail_addr = 0x10; memwrite low afterwards.
- Boundaries:
  - len=0 → done next cycle with no request;
  - op=11 → error next cycle with no request;
  - dst=0xFFFFFFFC, len=2 FILL → writes to 0xFFFFFFFC then 0x00000000;
  - start pulsed while busy → ignored.
- Reset mid-COPY during RD_WAIT → memread is 0 in the same cycle (asynchronous); busy/done/error are 0; a fresh command afterwards completes normally.
